// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds the PLL in reset, qualifies lock, then releases channel resets one by one.
// Optional lock-wait timeout with retry counting is built when RESET_SEQUENCER_TIMEOUT_EN is defined.
module reset_sequencer #(
   parameter int HOLD_WIDTH   = 24,
   parameter int HOLD_CYCLES  = 16777215,
   parameter int CHANNELS     = 2,
   parameter int STAGGER      = 16,
   parameter int LOCK_STABLE  = 256,
   parameter int LOCK_TIMEOUT = 1048576
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                pll_locked,
   output logic                pll_reset,
   output logic [CHANNELS-1:0] chan_reset_n,
   output logic                ready,
   output logic [1:0]          state,
   output logic [7:0]          retry_count
);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_LOCK    = 2'd1,
      S_STAGGER = 2'd2,
      S_RUN     = 2'd3
   } state_t;

   localparam int STAG_MAX = (CHANNELS - 1) * STAGGER;
   localparam int SW       = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
   localparam int GW       = (STAG_MAX > 0) ? $clog2(STAG_MAX + 1) : 1;

   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST   = HOLD_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0]         STABLE_LAST = SW'(LOCK_STABLE - 1);
   localparam logic [GW-1:0]         STAG_LAST   = GW'(STAG_MAX);

   if (CHANNELS < 1 || CHANNELS > 16 || STAGGER < 1 || LOCK_STABLE < 1 ||
       LOCK_TIMEOUT <= LOCK_STABLE + 2 || HOLD_CYCLES < 1) begin : g_param_check
      $error("reset_sequencer: parameter out of range");
   end

   state_t                  state_q;
   state_t                  state_nxt;
   logic [1:0]              sync_ff;
   logic                    lock_s;
   logic [HOLD_WIDTH-1:0]   hold_cnt;
   logic [SW-1:0]           stable_cnt;
   logic [GW-1:0]           stag_cnt;
   logic [CHANNELS-1:0]     chan_nxt;
   logic                    timeout_hit;

   assign lock_s = sync_ff[1];
   assign state  = state_q;

   // pll_locked comes from another clock domain; only lock_s is used downstream.
   always_ff @(posedge clock) begin
      if (!reset) sync_ff <= '0;
      else        sync_ff <= {sync_ff[0], pll_locked};
   end

   always_ff @(posedge clock) begin
      if (!reset) state_q <= S_HOLD;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_HOLD: begin
            if (hold_cnt == '0) state_nxt = S_LOCK;
         end
         S_LOCK: begin
            // Qualification wins over a timeout landing on the same edge.
            if (lock_s && stable_cnt == STABLE_LAST) state_nxt = S_STAGGER;
            else if (timeout_hit)                    state_nxt = S_HOLD;
         end
         S_STAGGER: begin
            if (!lock_s)                    state_nxt = S_HOLD;
            else if (stag_cnt == STAG_LAST) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!lock_s) state_nxt = S_HOLD;
         end
         default: state_nxt = S_HOLD;
      endcase
   end

   // ready is a level status (high only in RUN), not a handshake.
   always_comb begin
      pll_reset = (state_q == S_HOLD);
      ready     = (state_q == S_RUN);
   end

   // Hold counter parks at its reload value outside HOLD, so every HOLD entry starts full.
   always_ff @(posedge clock) begin
      if (!reset) begin
         hold_cnt   <= HOLD_LAST;
         stable_cnt <= '0;
         stag_cnt   <= '0;
      end else begin
         if (state_q != S_HOLD)   hold_cnt <= HOLD_LAST;
         else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

         if (state_q != S_LOCK || !lock_s)  stable_cnt <= '0;
         else if (stable_cnt != STABLE_LAST) stable_cnt <= stable_cnt + 1'b1;

         if (state_q != S_STAGGER)      stag_cnt <= '0;
         else if (stag_cnt != STAG_LAST) stag_cnt <= stag_cnt + 1'b1;
      end
   end

   always_comb begin
      chan_nxt = '0;
      case (state_q)
         S_STAGGER: begin
            if (lock_s) begin
               chan_nxt = chan_reset_n;
               for (int i = 0; i < CHANNELS; i++) begin
                  if (stag_cnt == GW'(i * STAGGER)) chan_nxt[i] = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (lock_s) chan_nxt = '1;
         end
         default: chan_nxt = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) chan_reset_n <= '0;
      else        chan_reset_n <= chan_nxt;
   end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
   localparam int             TW      = $clog2(LOCK_TIMEOUT);
   localparam logic [TW-1:0]  TO_LAST = TW'(LOCK_TIMEOUT - 1);

   logic [TW-1:0] to_cnt;
   logic [7:0]    retry_q;

   assign timeout_hit = (state_q == S_LOCK) && (to_cnt == TO_LAST);
   assign retry_count = retry_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         to_cnt  <= '0;
         retry_q <= '0;
      end else begin
         if (state_q != S_LOCK)     to_cnt <= '0;
         else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

         if (state_q == S_LOCK && state_nxt == S_HOLD && retry_q != 8'hFF)
            retry_q <= retry_q + 8'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: random and directed pll_locked/reset stimulus
// compared each cycle against a phase/elapsed-time reference model.
module tb_reset_sequencer;

   localparam int HOLD_WIDTH   = 4;
   localparam int HOLD_CYCLES  = 8;
   localparam int CHANNELS     = 3;
   localparam int STAGGER      = 3;
   localparam int LOCK_STABLE  = 4;
   localparam int LOCK_TIMEOUT = 32;
   localparam int W            = 12 + CHANNELS;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   logic                clock;
   logic                reset;
   logic                pll_locked;
   logic                pll_reset;
   logic [CHANNELS-1:0] chan_reset_n;
   logic                ready;
   logic [1:0]          state;
   logic [7:0]          retry_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_q[$];

   // reference model: phase (0..3), cycles spent in phase, run of lock_s ones in LOCK
   int m_phase   = 0;
   int m_elapsed = 0;
   int m_run     = 0;
   int m_retry   = 0;
   bit m_s1      = 0;
   bit m_s2      = 0;

   reset_sequencer #(
      .HOLD_WIDTH  (HOLD_WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES),
      .CHANNELS    (CHANNELS),
      .STAGGER     (STAGGER),
      .LOCK_STABLE (LOCK_STABLE),
      .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .pll_reset   (pll_reset),
      .chan_reset_n(chan_reset_n),
      .ready       (ready),
      .state       (state),
      .retry_count (retry_count)
   );

   // clock / reset
   initial begin
      clock      = 1'b0;
      reset      = 1'b0;
      pll_locked = 1'b0;
   end
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model_outputs();
      int released;
      logic [CHANNELS-1:0] mask;
      released = 0;
      if (m_phase == 2)
         released = (m_elapsed == 0) ? 0 :
                    (((m_elapsed - 1) / STAGGER + 1) > CHANNELS ? CHANNELS : (m_elapsed - 1) / STAGGER + 1);
      else if (m_phase == 3)
         released = CHANNELS;
      for (int i = 0; i < CHANNELS; i++) mask[i] = (i < released);
      return {2'(m_phase), (m_phase == 0), (m_phase == 3), mask, 8'(TIMEOUT_EN ? m_retry : 0)};
   endfunction

   task automatic enter(input int ph);
      m_phase   = ph;
      m_elapsed = 0;
      m_run     = 0;
   endtask

   task automatic model_step(input bit r, input bit p);
      bit cur;
      if (!r) begin
         enter(0);
         m_retry = 0;
         m_s1    = 0;
         m_s2    = 0;
      end else begin
         cur = m_s2;
         case (m_phase)
            0: if (m_elapsed == HOLD_CYCLES - 1) enter(1); else m_elapsed++;
            1: begin
               m_run = cur ? m_run + 1 : 0;
               if (m_run == LOCK_STABLE) enter(2);
               else if (TIMEOUT_EN && m_elapsed == LOCK_TIMEOUT - 1) begin
                  enter(0);
                  if (m_retry < 255) m_retry++;
               end else m_elapsed++;
            end
            2: if (!cur) enter(0);
               else if (m_elapsed >= (CHANNELS - 1) * STAGGER) enter(3);
               else m_elapsed++;
            default: if (!cur) enter(0);
         endcase
         m_s2 = m_s1;
         m_s1 = p;
      end
      exp_q.push_back(model_outputs());
   endtask

   // driver: one clock of stimulus, model update and scoreboard compare
   task automatic cycle(input bit r, input bit p);
      logic [W-1:0] e;
      @(negedge clock);
      reset      = r;
      pll_locked = p;
      @(posedge clock);
      model_step(r, p);
      #1;
      e = exp_q.pop_front();
      check("state",        32'(state),        32'(e[W-1:W-2]));
      check("pll_reset",    32'(pll_reset),    32'(e[W-3]));
      check("ready",        32'(ready),        32'(e[W-4]));
      check("chan_reset_n", 32'(chan_reset_n), 32'(e[W-5:8]));
      check("retry_count",  32'(retry_count),  32'(e[7:0]));
   endtask

   int  level;
   int  run_left;
   bit  seen;

   initial begin
      // reset state
      repeat (4) cycle(1'b0, 1'b1);
      check("rst_chan", 32'(chan_reset_n), 32'd0);
      check("rst_pll_reset", 32'(pll_reset), 32'd1);

      // nominal bring-up from reset release, lock held high
      for (int k = 1; k <= 30; k++) begin
         cycle(1'b1, 1'b1);
         if (k == 7)  check("hold_end_pll_reset", 32'(pll_reset), 32'd1);
         if (k == 8)  check("lock_entry", 32'(state), 32'd1);
         if (k == 11) check("still_lock", 32'(state), 32'd1);
         if (k == 12) check("stagger_entry", 32'(state), 32'd2);
         if (k == 13) check("chan_001", 32'(chan_reset_n), 32'h1);
         if (k == 16) check("chan_011", 32'(chan_reset_n), 32'h3);
         if (k == 18) check("ready_early", 32'(ready), 32'd0);
         if (k == 19) check("chan_111", 32'(chan_reset_n), 32'h7);
         if (k == 19) check("run_ready", 32'(ready), 32'd1);
      end

      // single-cycle lock drop in RUN restarts the sequence
      cycle(1'b1, 1'b0);
      for (int j = 1; j <= 30; j++) begin
         cycle(1'b1, 1'b1);
         if (j == 1)  check("drop_still_run", 32'(state), 32'd3);
         if (j == 2)  check("drop_hold", 32'(state), 32'd0);
         if (j == 2)  check("drop_chan", 32'(chan_reset_n), 32'd0);
         if (j == 21) check("drop_rerun", 32'(state), 32'd3);
      end

      // 3-high/1-low lock pattern never qualifies
      repeat (2) cycle(1'b0, 1'b0);
      for (int k = 1; k <= 80; k++) begin
         cycle(1'b1, (k % 4) != 0);
         check("no_stagger", 32'(state == 2'd2), 32'd0);
      end

      // reset asserted mid-STAGGER
      repeat (2) cycle(1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle(1'b1, 1'b1);
         if (chan_reset_n == 3'b011) seen = 1'b1;
      end
      check("wait_chan_011", 32'(seen), 32'd1);
      cycle(1'b0, 1'b1);
      check("midrst_chan", 32'(chan_reset_n), 32'd0);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_retry", 32'(retry_count), 32'd0);

      // random lock runs with occasional resets
      level    = 1;
      run_left = 0;
      for (int k = 0; k < 3000; k++) begin
         if (run_left == 0) begin
            level    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            run_left = $urandom_range(1, 60);
         end
         run_left--;
         cycle($urandom_range(0, 199) != 0, level[0]);
      end

      // lock never arrives
      repeat (2) cycle(1'b0, 1'b0);
`ifdef RESET_SEQUENCER_TIMEOUT_EN
      for (int k = 0; k < 255 * 40 + 100; k++) cycle(1'b1, 1'b0);
      check("retry_saturated", 32'(retry_count), 32'd255);
`else
      for (int k = 0; k < 1000; k++) cycle(1'b1, 1'b0);
      check("wait_forever_state", 32'(state), 32'd1);
      check("wait_forever_retry", 32'(retry_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_WIDTH, default 24, giving the width of the hold counter.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16777215, giving the PLL reset hold duration in clock cycles (range 1..2^HOLD_WIDTH-1).
REQ-003 The block SHALL have parameter CHANNELS, default 2, giving the number of downstream reset outputs (range 1..16).
REQ-004 The block SHALL have parameter STAGGER, default 16, giving the cycles between successive channel releases (range >=1).
REQ-005 The block SHALL have parameter LOCK_STABLE, default 256, giving the consecutive synchronised-lock cycles required to qualify lock (range >=1).
REQ-006 The block SHALL have parameter LOCK_TIMEOUT, default 1048576, giving the lock wait limit in cycles (range >LOCK_STABLE+2).
REQ-007 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-009 The block SHALL have port pll_locked, input, 1 bit: asynchronous PLL lock indication.
REQ-010 The block SHALL have port pll_reset, output, 1 bit: active-high PLL reset.
REQ-011 The block SHALL have port chan_reset_n, output, CHANNELS bits: active-low per-channel resets, registered.
REQ-012 The block SHALL have port ready, output, 1 bit: high only in RUN.
REQ-013 The block SHALL have port state, output, 2 bits: current state encoding.
REQ-014 The block SHALL have port retry_count, output, 8 bits: number of lock timeouts.

Function
REQ-015 The block SHALL pass pll_locked through a two-flop synchroniser (lock_s); lock_s lags pll_locked by 2 cycles.
REQ-016 The block SHALL implement states HOLD=0, LOCK=1, STAGGER=2, RUN=3.
REQ-017 In HOLD: pll_reset=1, chan_reset_n all 0, ready=0; counter loads HOLD_CYCLES-1 on entry and decrements each cycle; at counter==0, next state is LOCK, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-018 In LOCK: pll_reset=0; a stable counter increments while lock_s=1 and clears to 0 when lock_s=0; when lock_s=1 and the stable counter equals LOCK_STABLE-1, next state is STAGGER.
REQ-019 In STAGGER: a counter starts at 0 on entry; chan_reset_n[i] goes to 1 on the edge after counter==i*STAGGER (channel 0 one cycle after entry); a released channel stays 1; after channel CHANNELS-1 is released, next state is RUN.
REQ-020 In RUN: ready=1, all chan_reset_n=1, pll_reset=0.
REQ-021 lock_s=0 in STAGGER or RUN SHALL cause HOLD on the next edge, with all chan_reset_n=0 and pll_reset=1 in that same edge (lock-loss restart).
REQ-022 A lock_s glitch in LOCK SHALL only clear the stable counter; no state change.
REQ-023 Counters SHALL be sized by $clog2 of their maximum, SHALL NOT wrap, and SHALL compare with no truncation.

Reset
REQ-024 While reset=0, every edge SHALL force: state=HOLD, counter=HOLD_CYCLES-1, pll_reset=1, chan_reset_n=0, ready=0, retry_count=0, synchroniser flops=0.
REQ-025 Reset held low SHALL keep reloading the hold counter, so the HOLD duration is measured from reset release.
REQ-026 Reset asserted mid-sequence (any state) SHALL take effect on the next edge with no residual channel release.

Configuration
REQ-027 With RESET_SEQUENCER_TIMEOUT_EN defined: a timeout counter clears on LOCK entry; if it reaches LOCK_TIMEOUT-1 before lock is qualified, next state is HOLD and retry_count increments, saturating at 255; qualification and timeout on the same edge resolve to STAGGER.
REQ-028 Without RESET_SEQUENCER_TIMEOUT_EN: LOCK waits indefinitely, no timeout logic is built, and retry_count is constant 0.

Verification (HOLD_CYCLES=8, LOCK_STABLE=4, STAGGER=3, CHANNELS=3, LOCK_TIMEOUT=32)
REQ-029 Release reset at cycle 0, pll_locked=1 throughout -> pll_reset=1 for cycles 0..7, state=LOCK at cycle 8, STAGGER qualified after 4 lock_s cycles, chan_reset_n 001/011/111 at 3-cycle spacing, ready=1 after the last channel release.
REQ-030 In RUN, drop pll_locked for 1 cycle -> 2 cycles later state=HOLD, chan_reset_n=000, pll_reset=1, ready=0, full sequence repeats.
REQ-031 In LOCK, pll_locked toggling with a 3-cycle high / 1-cycle low pattern -> remains in LOCK, never reaches STAGGER.
REQ-032 Macro defined, pll_locked=0 -> HOLD re-entered every 8+32 cycles; retry_count reaches 255 and holds at 255.
REQ-033 Assert reset during STAGGER after chan_reset_n=011 -> next edge chan_reset_n=000, state=HOLD, retry_count=0.
REQ-034 Macro undefined, pll_locked=0 for 1000 cycles -> state stays LOCK, retry_count=0.
